uart_wrapper: RTL and testbench

UART_WRAPPER -- requirements
Module: uart_wrapper

---
 rtl/uart_wrapper_pkg.sv | 31 +++
 rtl/uart_wrapper_rx.sv | 99 +++++++++
 rtl/uart_wrapper.sv | 138 +++++++++++++
 tb/tb_uart_wrapper.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wrapper_pkg.sv
// Shared types and constants for the UART command wrapper: FSM encodings,
// command payload layout and the opcodes carried in the command high byte.
package uart_wrapper_pkg;

  localparam int unsigned CNT_W      = 12;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_W      = 16;
  localparam int unsigned BIT_IDX_W  = 4;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(9);

  typedef enum logic {HIGH, LOW} asm_state_e;
  typedef enum logic {IDLE, XMIT} tx_state_e;
  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_e;

  typedef enum logic [BYTE_W-1:0] {
    OP_NOP    = 8'h00,
    OP_STATUS = 8'h20,
    OP_WRITE  = 8'h2F,
    OP_READ   = 8'h4B
  } cmd_op_e;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } cmd_t;

  function automatic logic [BYTE_W-1:0] cmd_opcode(input cmd_t c);
    return c.hi;
  endfunction

endpackage

// File: rtl/uart_wrapper_rx.sv
// 8N1 receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling.
// Emits a one-cycle rx_rdy with the byte when the stop bit samples high.
module uart_rx
  import uart_wrapper_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_rdy
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BYTE_W-1:0]    rx_byte_q, rx_byte_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic                 sample;

  // Synchronizer chain preset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      rx_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      rx_rdy_q  <= rx_rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    rx_rdy_d  = 1'b0;
    sample    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RX_BUSY;
      end
      RX_BUSY: begin
        // Start bit is sampled half a bit in; every later bit one full bit on.
        sample = (bit_idx_q == '0) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);
        if (!sample) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == '0) begin
            if (rx_sync_q) state_d = RX_IDLE;
          end else if (bit_idx_q < LAST_BIT) begin
            shift_d = {rx_sync_q, shift_q[BYTE_W-1:1]};
          end else begin
            state_d = RX_IDLE;
            if (rx_sync_q) begin
              rx_rdy_d  = 1'b1;
              rx_byte_d = shift_q;
            end
          end
        end
      end
    endcase
  end

  assign rx_byte = rx_byte_q;
  assign rx_rdy  = rx_rdy_q;

endmodule

// File: rtl/uart_wrapper.sv
// UART command front end: pairs received bytes into 16-bit commands (high
// byte first) and transmits one response byte per send_resp request.
module uart_wrapper
  import uart_wrapper_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  output logic              resp_sent
);

  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_rdy;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_byte (rx_byte),
    .rx_rdy  (rx_rdy)
  );

  asm_state_e           asm_q, asm_d;
  logic [BYTE_W-1:0]    hi_q, hi_d;
  cmd_t                 cmd_q, cmd_d;
  logic                 cmd_rdy_q, cmd_rdy_d;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_IDX_W-1:0] tx_bit_q, tx_bit_d;
  logic [BYTE_W:0]      tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 resp_sent_q, resp_sent_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= HIGH;
      hi_q        <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '1;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // Command assembler; a completing low byte overrides a same-cycle clear.
  always_comb begin
    asm_d     = asm_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_rdy) begin
      case (asm_q)
        HIGH: begin
          hi_d      = rx_byte;
          cmd_rdy_d = 1'b0;
          asm_d     = LOW;
        end
        LOW: begin
          cmd_d.hi  = hi_q;
          cmd_d.lo  = rx_byte;
          cmd_rdy_d = 1'b1;
          asm_d     = HIGH;
        end
      endcase
    end
  end

  // Transmitter; the shift register refills with stop-level ones.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (send_resp) begin
          tx_shift_d = {1'b1, resp};
          tx_d       = 1'b0;
          tx_state_d = XMIT;
        end
      end
      XMIT: begin
        if (tx_cnt_q == FULL_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d  = IDLE;
            tx_d        = 1'b1;
            resp_sent_d = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_IDX_W'(1);
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[BYTE_W:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Bench for uart_wrapper: drives serial frames into RX, watches TX, and
// compares against a byte-pairing reference model.
module tb_uart_wrapper;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  uart_wrapper #(.BAUD_DIV(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  // Reference: valid bytes pair up high-then-low; bad frames are dropped.
  int          pend_hi = -1;
  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  int          last_lat = 9 * B + B / 2 + 4;

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) return;
    if (pend_hi < 0) begin
      pend_hi = int'(b);
      exp_rdy = 1'b0;
    end else begin
      exp_cmd = {pend_hi[7:0], b};
      exp_rdy = 1'b1;
      pend_hi = -1;
    end
  endfunction

  function automatic void model_reset();
    pend_hi = -1;
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
  endfunction

  int   cyc = 0;
  int   rise_cyc = -1;
  logic rdy_prev = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) rise_cyc = cyc;
    rdy_prev = cmd_rdy;
  end

  // One RX frame; clr_k / rst_k (bit-time offsets, -1 = none) inject clear or reset.
  task automatic rx_frame(input logic [7:0] b, input bit ok, input int clr_k,
                          input int rst_k, input string tag);
    logic [9:0] fr;
    int         t0, lat;
    bit         completes;
    fr = {logic'(ok), b, 1'b0};
    completes = ok && (pend_hi >= 0) && (rst_k < 0);
    @(posedge clk); #1;
    t0 = cyc;
    rise_cyc = -1;
    for (int k = 0; k < 10 * B; k++) begin
      RX = fr[k / B];
      clr_cmd_rdy = (k == clr_k);
      if (k == rst_k) rst_n = 1'b0;
      if (k == rst_k + 3) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    clr_cmd_rdy = 1'b0;
    RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (rst_k >= 0) model_reset();
    else model_byte(b, ok);
    check_eq({tag, ".cmd"}, 32'(cmd), 32'(exp_cmd));
    check_eq({tag, ".cmd_rdy"}, 32'(cmd_rdy), 32'(exp_rdy));
    if (rst_k >= 0) check_eq({tag, ".no_rdy_after_reset"}, 32'(rise_cyc == -1), 32'd1);
    if (completes) begin
      lat = rise_cyc - t0;
      last_lat = lat;
      check_eq($sformatf("%s.rdy_latency=%0d_in_window", tag, lat),
               32'(lat >= 9 * B + B / 2 + 1 && lat <= 9 * B + B / 2 + 5), 32'd1);
    end
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
  endtask

  // One TX frame, optionally with a second request landing mid-frame.
  task automatic tx_frame(input logic [7:0] r, input bit second, input string tag);
    logic [9:0] fr;
    logic       exp_tx;
    int         bad = 0, pulses = 0, pulse_n = -1, late_low = 0;
    fr = {1'b1, r, 1'b0};
    @(posedge clk); #1;
    resp = r;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
    resp = ~r;
    for (int n = 0; n < 10 * B + 2 * B; n++) begin
      @(negedge clk);
      exp_tx = (n < 10 * B) ? fr[n / B] : 1'b1;
      if (n < 10 * B + 2) begin
        if (TX !== exp_tx) bad++;
      end else if (TX !== 1'b1) late_low++;
      if (resp_sent === 1'b1) begin
        pulses++;
        pulse_n = n;
      end
      if (second && n == 3 * B) begin
        send_resp = 1'b1;
        resp = 8'h0F;
      end else if (second && n == 3 * B + 1) begin
        send_resp = 1'b0;
      end
    end
    check_eq({tag, ".tx_bit_errors"}, 32'(bad), 32'd0);
    check_eq({tag, ".resp_sent_count"}, 32'(pulses), 32'd1);
    check_eq({tag, ".resp_sent_cycle"}, 32'(pulse_n), 32'(10 * B));
    check_eq({tag, ".tx_idle_after"}, 32'(late_low), 32'd0);
  endtask

  // Transmit aborted by reset: line must go idle and no completion pulse.
  task automatic tx_abort();
    int lows = 0, pulses = 0;
    @(posedge clk); #1;
    resp = 8'h3C;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
    repeat (3 * B) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 10 * B; n++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
      if (resp_sent === 1'b1) pulses++;
    end
    check_eq("tx_abort.tx_idle", 32'(lows), 32'd0);
    check_eq("tx_abort.no_resp_sent", 32'(pulses), 32'd0);
    check_eq("tx_abort.cmd", 32'(cmd), 32'(exp_cmd));
  endtask

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bit         rok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset.TX", 32'(TX), 32'd1);
    check_eq("reset.cmd", 32'(cmd), 32'd0);
    check_eq("reset.cmd_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("reset.resp_sent", 32'(resp_sent), 32'd0);
    rst_n = 1'b1;

    rx_frame(8'h4B, 1'b1, -1, -1, "cmd4bf1.hi");
    rx_frame(8'hF1, 1'b1, -1, -1, "cmd4bf1.lo");

    clr_pulse();
    @(negedge clk);
    check_eq("clr.cmd_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("clr.cmd_kept", 32'(cmd), 32'h4BF1);

    rx_frame(8'h2F, 1'b1, -1, -1, "hi_only");
    rx_frame(8'hC3, 1'b1, last_lat - 1, -1, "set_wins");

    rx_frame(8'h4B, 1'b0, -1, -1, "framing.bad");
    rx_frame(8'h4B, 1'b1, -1, -1, "framing.hi");
    rx_frame(8'hF1, 1'b1, -1, -1, "framing.lo");

    tx_frame(8'hA5, 1'b1, "tx_a5");

    rx_frame(8'h4B, 1'b1, -1, -1, "rst_mid.hi");
    rx_frame(8'hF1, 1'b1, -1, 5 * B + B / 2, "rst_mid.lo");
    rx_frame(8'h20, 1'b1, -1, -1, "cmd2002.hi");
    rx_frame(8'h02, 1'b1, -1, -1, "cmd2002.lo");

    tx_abort();

    fork
      begin
        rx_frame(8'h4B, 1'b1, -1, -1, "duplex.hi");
        rx_frame(8'hF1, 1'b1, -1, -1, "duplex.lo");
      end
      tx_frame(8'hA5, 1'b0, "duplex.tx");
    join

    for (int i = 0; i < 16; i++) begin
      rb  = 8'($urandom);
      rok = ($urandom % 4) != 0;
      rx_frame(rb, rok, -1, -1, $sformatf("rand%0d", i));
      if ($urandom % 4 == 0) begin
        clr_pulse();
        @(negedge clk);
        check_eq($sformatf("rand%0d.clr", i), 32'(cmd_rdy), 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'($urandom % 2), $sformatf("rand_tx%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
